rca_accumulator_16: RTL and testbench
=====================================

// Module: rca_accumulator_16
// PURPOSE
//   Streaming 16-bit accumulator built around the RCA_16bit ripple-carry adder.
//   Accepts a burst of operands over a valid/ready handshake.
//   Adds each operand into a running sum and tracks sticky carry-out and beat count.
//   Presents the final sum downstream when the beat marked last has been added.
//   Sits directly downstream of RCA_16bit: registers its s/c outputs and feeds s back into its a input.
// PARAMETERS
//   CNT_W   8   width of beat counter; counter saturates at 2**CNT_W-1
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      block can accept an operand this cycle
//   in_data    in   16     operand to add
//   in_last    in   1      qualifies the final beat of a burst
//   clear      in   1      synchronous clear of the running sum (accumulate state only)
//   out_valid  out  1      result available
//   out_ready  in   1      downstream accepts the result
//   out_sum    out  16     accumulated sum, modulo 2**16
//   out_carry  out  1      sticky OR of every adder carry-out in this burst
//   out_count  out  CNT_W  beats accumulated in this burst, saturating
// BEHAVIOUR
//   - Reset:
//     - State ACC; acc, carry and count all 0.
//     - in_ready=1, out_valid=0, out_sum=0, out_carry=0, out_count=0.
//     - Reset mid-burst discards the partial sum; no output is produced for that burst.
//   - Adder path:
//     - RCA_16bit with a=acc, b=in_data (or 0 when clear), c0=1'b0.
//     - Purely combinational; acc is the only data register.
//   - Outputs: out_sum/out_carry/out_count are the acc/carry/count registers directly.
//     - They are valid only while out_valid=1.
//   - State ACC: in_ready=1, out_valid=0.
//     - Accept = in_valid & in_ready.
//     - On accept: acc<=s; carry<=carry|c; count<=count+1, saturating at all-ones.
//     - On accept with in_last=1: go to DONE. out_valid=1 on the next cycle with the updated sum (latency 1).
//     - clear without accept: acc<=0, carry<=0, count<=0.
//     - clear with accept: the beat starts a new burst. acc<=in_data, carry<=0, count<=1.
//       in_last is still honoured.
//   - State DONE: in_ready=0, out_valid=1; outputs are held stable.
//     - clear is ignored; in_valid is ignored.
//     - out_ready=1: acc, carry and count <=0 and go to ACC. in_ready=1 from the next cycle (no bypass).
//     - out_ready=0: remain in DONE indefinitely.
//   - Wrap-around: acc wraps modulo 2**16 and sets carry; accumulation continues.
//   - Count: stops at 2**CNT_W-1; no wrap.
//   - Single-beat burst (in_last on the first beat): out_sum=in_data, out_count=1.
// STRUCTURE
//   - Shared package: state encoding localparams ST_ACC=1'b0, ST_DONE=1'b1, and data width constant 16.
//   - One sub-module: RCA_16bit (existing adder, ports a,b,c0,s,c), instantiated once.
//   - Rest of the block: 1-bit FSM plus acc/carry/count registers; no other hierarchy.
// TESTING
//   1. Basic sum: beats 0x02EB, 0x5555(last), out_ready=1
//      -> out_sum=0x5840, out_carry=0, out_count=2, out_valid high exactly 1 cycle.
//   2. Wrap: beats 0xFFFF, 0x0002(last) -> out_sum=0x0001, out_carry=1, out_count=2.
//   3. Saturation: 300 beats of 0x0001, last on the 300th -> out_sum=0x012C, out_count=0xFF.
//   4. Backpressure: after result, hold out_ready=0 for 5 cycles while in_valid=1
//      -> out_valid stays 1, in_ready=0, outputs stable, no beat consumed.
//      Raise out_ready -> in_ready=1 on the next cycle.
//   5. Clear+accept: accumulate 0x1234, then clear with beat 0x0007(last)
//      -> out_sum=0x0007, out_count=1, out_carry=0.
//   6. Reset mid-burst: beats 0x1000, 0x2000, assert rst 1 cycle, then 0x0003(last)
//      -> out_sum=0x0003, out_count=1.

Source files
------------

// File: rtl/rca_accumulator_16_pkg.sv
// Shared definitions for the streaming ripple-carry accumulator.
package rca_accumulator_16_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

endpackage

// File: rtl/rca_accumulator_16_rca.sv
// RCA_16bit: 16-bit ripple-carry adder built from a chain of full adders.
import rca_accumulator_16_pkg::*;

module RCA_16bit (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c0,
  output logic [DATA_W-1:0] s,
  output logic              c
);

  logic [DATA_W:0] carry_chain;

  assign carry_chain[0] = c0;

  for (genvar i = 0; i < DATA_W; i++) begin : g_fa
    assign s[i]               = a[i] ^ b[i] ^ carry_chain[i];
    assign carry_chain[i + 1] = (a[i] & b[i]) | (carry_chain[i] & (a[i] ^ b[i]));
  end

  assign c = carry_chain[DATA_W];

endmodule

// File: rtl/rca_accumulator_16.sv
// Streaming accumulator: sums a handshaked burst through RCA_16bit and presents the result once.
import rca_accumulator_16_pkg::*;

module rca_accumulator_16 #(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_carry,
  output logic [CNT_W-1:0]  out_count
);

  state_e             state;
  state_e             state_next;
  logic [DATA_W-1:0]  acc;
  logic               carry;
  logic [CNT_W-1:0]   count;
  logic [DATA_W-1:0]  adder_b;
  logic [DATA_W-1:0]  adder_s;
  logic               adder_c;
  logic               accept;

  assign adder_b = clear ? '0 : in_data;

  RCA_16bit u_rca (
    .a  (acc),
    .b  (adder_b),
    .c0 (1'b0),
    .s  (adder_s),
    .c  (adder_c)
  );

  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid & in_ready;

  assign out_sum   = acc;
  assign out_carry = carry;
  assign out_count = count;

  always_comb begin
    state_next = state;
    case (state)
      ST_ACC:  if (accept && in_last) state_next = ST_DONE;
      ST_DONE: if (out_ready)         state_next = ST_ACC;
      default: state_next = ST_ACC;
    endcase
  end

  // A clear arriving with a beat restarts the burst with that beat as its first operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACC;
      acc   <= '0;
      carry <= 1'b0;
      count <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_ACC: begin
          if (accept) begin
            if (clear) begin
              acc   <= in_data;
              carry <= 1'b0;
              count <= CNT_W'(1);
            end else begin
              acc   <= adder_s;
              carry <= carry | adder_c;
              count <= (count == '1) ? count : count + 1'b1;
            end
          end else if (clear) begin
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_accumulator_16.sv
// Directed self-checking bench for rca_accumulator_16 with hand-computed expected results.
module tb_rca_accumulator_16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_carry;
  logic [7:0]  out_count;

  int checks = 0;
  int errors = 0;

  rca_accumulator_16 #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Called at a falling edge; the beat is taken at the following rising edge.
  task automatic applyStimulus(input logic [15:0] data, input logic last, input logic clr);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    clear    = clr;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    clear    = 1'b0;
    in_data  = '0;
  endtask

  task automatic clearOnly();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic waitResult(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic checkResult(input string tag, input logic [15:0] sum, input logic carry,
                             input logic [7:0] count);
    checkOutput({tag, "_sum"},   32'(out_sum),   32'(sum));
    checkOutput({tag, "_carry"}, 32'(out_carry), 32'(carry));
    checkOutput({tag, "_count"}, 32'(out_count), 32'(count));
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_ready_back"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkResult("rst", 16'h0000, 1'b0, 8'd0);

    $display("[TB] basic sum");
    applyStimulus(16'h02EB, 1'b0, 1'b0);
    checkOutput("basic_mid_valid", 32'(out_valid), 32'd0);
    applyStimulus(16'h5555, 1'b1, 1'b0);
    waitResult("basic");
    checkResult("basic", 16'h5840, 1'b0, 8'd2);
    releaseResult("basic");

    $display("[TB] wrap");
    applyStimulus(16'hFFFF, 1'b0, 1'b0);
    applyStimulus(16'h0002, 1'b1, 1'b0);
    waitResult("wrap");
    checkResult("wrap", 16'h0001, 1'b1, 8'd2);
    releaseResult("wrap");

    $display("[TB] saturation");
    for (int i = 1; i <= 300; i++) applyStimulus(16'h0001, (i == 300), 1'b0);
    waitResult("sat");
    checkResult("sat", 16'h012C, 1'b0, 8'hFF);

    $display("[TB] backpressure");
    in_valid = 1'b1;
    in_data  = 16'h0F0F;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready",  32'(in_ready),  32'd0);
      checkResult("bp", 16'h012C, 1'b0, 8'hFF);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    out_ready = 1'b1;
    checkOutput("bp_in_ready_same_cycle", 32'(in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_in_ready_next", 32'(in_ready),  32'd1);
    checkOutput("bp_valid_drop",    32'(out_valid), 32'd0);
    checkResult("bp_cleared", 16'h0000, 1'b0, 8'd0);

    $display("[TB] clear with accept");
    applyStimulus(16'hF234, 1'b0, 1'b0);
    applyStimulus(16'h1234, 1'b0, 1'b0);
    applyStimulus(16'h0007, 1'b1, 1'b1);
    waitResult("clracc");
    checkResult("clracc", 16'h0007, 1'b0, 8'd1);
    releaseResult("clracc");

    $display("[TB] clear without accept");
    applyStimulus(16'hFFFF, 1'b0, 1'b0);
    applyStimulus(16'h00FF, 1'b0, 1'b0);
    clearOnly();
    checkResult("clronly_zero", 16'h0000, 1'b0, 8'd0);
    applyStimulus(16'h0010, 1'b1, 1'b0);
    waitResult("clronly");
    checkResult("clronly", 16'h0010, 1'b0, 8'd1);
    releaseResult("clronly");

    $display("[TB] reset mid-burst");
    applyStimulus(16'h1000, 1'b0, 1'b0);
    applyStimulus(16'h2000, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready",  32'(in_ready),  32'd1);
    applyStimulus(16'h0003, 1'b1, 1'b0);
    waitResult("midrst");
    checkResult("midrst", 16'h0003, 1'b0, 8'd1);
    releaseResult("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
